decoder_input_streamer: RTL
===========================

# decoder_input_streamer

Producer for the decoder block's `x_t` input stream. A host loads a vector of up to `DEPTH` words into an internal buffer, then issues a start command with a length. The block then drives the words out in order on a valid/ready stream that connects directly to the decoder block's `in_valid`/`in_ready`/`x_t_data` inputs. Completion is signalled with a one-cycle `done` pulse.

## Interface
Parameters:
- `DATA_WIDTH`, 16, word width; matches the decoder block.
- `DEPTH`, 64, number of buffer entries; power of two, ≥2.
- `LEN_WIDTH`, `$clog2(DEPTH)+1`, width of the command length field.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `wr_en`  in  1  host buffer write strobe.
- `wr_addr`  in  `$clog2(DEPTH)`  host write address.
- `wr_data`  in  `DATA_WIDTH`  host write data.
- `cmd_valid`  in  1  start-command valid.
- `cmd_ready`  out  1  block is idle and accepts a command.
- `cmd_len`  in  `LEN_WIDTH`  number of words to stream.
- `out_valid`  out  1  stream valid (drives decoder `in_valid`).
- `out_ready`  in  1  stream ready (from decoder `in_ready`).
- `out_data`  out  `DATA_WIDTH`  stream word (drives decoder `x_t_data`).
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse when a command completes.
- `out_last`  out  1  last-beat marker; present only with the macro defined (see Configuration).

## Operation
- FSM states: IDLE, STREAM, DONE.
- **IDLE:**
  - `cmd_ready=1`.
  - `wr_en` writes `buf[wr_addr]<=wr_data`.
  - On `cmd_valid&&cmd_ready`, `len` is latched as `min(cmd_len, DEPTH)`.
  - If `len==0`, go to DONE (no beats). Otherwise `out_data<=buf[0]`, `out_valid<=1`, `idx<=1`, go to STREAM.
- **STREAM:**
  - A beat completes when `out_valid&&out_ready`.
  - If the beat was not the last: `out_data<=buf[idx]`, `idx<=idx+1`, `out_valid` stays 1.
  - If the beat was the last: `out_valid<=0`, go to DONE.
- **DONE:** `done=1` for exactly this one cycle, then go to IDLE.
- `wr_en` is ignored outside IDLE, so buffer contents are frozen while streaming.
- A write and a command accepted in the same IDLE cycle: the write lands, but beat 0 reads the pre-write contents of `buf[0]`.
- The beat counter compares against the latched `len`. `idx` never wraps, because `len≤DEPTH`.
- The buffer is not cleared by reset; its contents are undefined until written.

## Timing
- Reset values: `cmd_ready=1`, `out_valid=0`, `out_data=0`, `busy=0`, `done=0`, `out_last=0`, state IDLE, `idx=0`.
- Command accepted in cycle N → `out_valid=1` with word 0 in cycle N+1.
- With `out_ready` held high, `len` beats occupy cycles N+1…N+len, `done` pulses in N+len+1, and `cmd_ready=1` again in N+len+2.
- With `len=0`: `done` in N+1, `cmd_ready` in N+2.
- AXI-style stream rules:
  - Once `out_valid` rises it stays high, and `out_data` stays stable, until a handshake completes.
  - `out_valid` never depends combinationally on `out_ready`.
- Back-pressure of any length stalls the stream with no lost or duplicated words.
- `rst_n` low mid-stream: the stream aborts immediately to the reset values, no `done` pulse is issued, and the consumer sees `out_valid` drop.
- All outputs are registered except `cmd_ready` and `busy`, which decode directly from the state register.

## Configuration
- Macro: `DECODER_STREAM_LAST_EN`.
- **Defined:**
  - The `out_last` port exists.
  - It is high together with `out_valid` on the final beat (`idx==len` while in STREAM) and is held under back-pressure.
- **Undefined:**
  - The `out_last` port and its logic are absent.
  - All other behaviour is identical.

## Structure
- Package `decoder_stream_pkg` holds:
  - the `stream_state_e` enum (IDLE, STREAM, DONE);
  - the default `DEPTH` and `DATA_WIDTH` localparams;
  - a `len_t` typedef helper.
- Sub-module `stream_buffer`:
  - `DEPTH×DATA_WIDTH` register file;
  - one synchronous write port, one asynchronous read port;
  - no reset.
- The top holds the FSM, index/length counters and output registers.

## Test plan
- **Basic stream:** write `buf[i]=16'h1000+i` for i=0..7; command `len=8` with `out_ready=1` → words `16'h1000`..`16'h1007` on 8 consecutive cycles, `done` one cycle later, and `out_last` on `16'h1007` when the macro is defined.
- **Back-pressure:** `len=4`, `out_ready` toggling 1,0,0,1,… → every word appears exactly once, in order, and `out_data` is stable during every stall.
- **Zero and oversize lengths:** `cmd_len=0` → no `out_valid`, `done` in N+1. `cmd_len=DEPTH+5` → exactly `DEPTH` beats.
- **Busy protection:**
  - A `wr_en` to `buf[3]` during STREAM → the streamed word 3 keeps its old value.
  - `cmd_valid` held high during STREAM → no second command is accepted until `cmd_ready` returns.
- **Reset mid-stream:** `rst_n` low after beat 2 of 8 → `out_valid=0` and `cmd_ready=1` immediately, with no `done` pulse. A new `len=2` command after release streams normally.

Source files
------------

// File: rtl/decoder_input_streamer_pkg.sv
// ---------------------------------------------------------------------------
// decoder_stream_pkg
// Shared types and defaults for the decoder input streamer.
//   stream_state_e : FSM encoding (IDLE, STREAM, DONE)
//   DEF_DEPTH      : default number of buffer entries
//   DEF_DATA_WIDTH : default word width (matches the decoder's x_t input)
//   len_t          : command length type for the default depth
// ---------------------------------------------------------------------------
package decoder_stream_pkg;

    localparam int DEF_DEPTH      = 64;
    localparam int DEF_DATA_WIDTH = 16;

    // One extra bit so a full-buffer length (== DEPTH) is representable.
    typedef logic [$clog2(DEF_DEPTH):0] len_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } stream_state_e;

endpackage

// File: rtl/decoder_input_streamer_buffer.sv
// ---------------------------------------------------------------------------
// stream_buffer
// DEPTH x DATA_WIDTH register file holding the vector to be streamed.
// One synchronous write port, one asynchronous (combinational) read port.
// Contents are deliberately not reset.
// Ports:
//   clk     in  clock
//   wr_en   in  write strobe
//   wr_addr in  write address
//   wr_data in  write data
//   rd_addr in  read address
//   rd_data out read data (combinational from rd_addr)
// ---------------------------------------------------------------------------
module stream_buffer
    import decoder_stream_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // A read in the same cycle as a write to that address returns the old word.
    assign rd_data = r_mem[rd_addr];

endmodule

// File: rtl/decoder_input_streamer.sv
// ---------------------------------------------------------------------------
// decoder_input_streamer
// Streams a host-loaded vector into the decoder's x_t valid/ready input.
// The host fills the buffer while idle, then issues a command with a length;
// the block emits buf[0..len-1] in order and pulses done for one cycle.
//
// Optional feature macro: DECODER_STREAM_LAST_EN (adds the out_last port).
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   wr_en/wr_addr/wr_data  host buffer write (honoured only in IDLE)
//   cmd_valid/cmd_ready/cmd_len  start command handshake and length
//   out_valid/out_ready/out_data stream to decoder
//   busy                high whenever not IDLE
//   done                one-cycle completion pulse
//   out_last            final-beat marker (macro builds only)
// ---------------------------------------------------------------------------
module decoder_input_streamer
    import decoder_stream_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int LEN_WIDTH  = $clog2(DEPTH) + 1,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  busy,
    output logic                  done
`ifdef DECODER_STREAM_LAST_EN
    ,output logic                 out_last
`endif
);

    localparam logic [LEN_WIDTH-1:0] LEN_ONE   = LEN_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0] LEN_DEPTH = LEN_WIDTH'(DEPTH);

    stream_state_e         r_state;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [LEN_WIDTH-1:0]  r_idx;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_done;
`ifdef DECODER_STREAM_LAST_EN
    logic                  r_out_last;
`endif

    logic                  w_idle;
    logic                  w_cmd_fire;
    logic [LEN_WIDTH-1:0]  w_len_clamped;
    logic                  w_beat;
    logic                  w_final_beat;
    logic [LEN_WIDTH-1:0]  w_idx_next;
    logic [AW-1:0]         w_rd_addr;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic                  w_buf_we;

    assign w_idle        = (r_state == ST_IDLE);
    assign w_cmd_fire    = cmd_valid && w_idle;
    assign w_len_clamped = (cmd_len > LEN_DEPTH) ? LEN_DEPTH : cmd_len;
    assign w_beat        = r_out_valid && out_ready;
    // r_idx counts words already loaded into the output register, so the
    // word currently on the bus is the last one exactly when r_idx == r_len.
    assign w_final_beat  = (r_idx == r_len);
    assign w_idx_next    = r_idx + LEN_ONE;

    // In IDLE the only word we may need is buf[0] (beat 0 on command accept).
    // r_idx reaches DEPTH only on the final beat, where the read is unused,
    // so truncating to AW bits never aliases a needed entry.
    assign w_rd_addr = w_idle ? '0 : r_idx[AW-1:0];

    // Freeze the buffer while a command is in flight.
    assign w_buf_we  = wr_en && w_idle;

    stream_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_buf (
        .clk     (clk),
        .wr_en   (w_buf_we),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (w_rd_addr),
        .rd_data (w_rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_len       <= '0;
            r_idx       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_done      <= 1'b0;
`ifdef DECODER_STREAM_LAST_EN
            r_out_last  <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_cmd_fire) begin
                        r_len <= w_len_clamped;
                        if (w_len_clamped == '0) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_out_data  <= w_rd_data;
                            r_out_valid <= 1'b1;
                            r_idx       <= LEN_ONE;
`ifdef DECODER_STREAM_LAST_EN
                            r_out_last  <= (w_len_clamped == LEN_ONE);
`endif
                            r_state     <= ST_STREAM;
                        end
                    end
                end
                ST_STREAM: begin
                    if (w_beat) begin
                        if (w_final_beat) begin
                            r_out_valid <= 1'b0;
`ifdef DECODER_STREAM_LAST_EN
                            r_out_last  <= 1'b0;
`endif
                            r_state     <= ST_DONE;
                            r_done      <= 1'b1;
                        end else begin
                            r_out_data <= w_rd_data;
                            r_idx      <= w_idx_next;
`ifdef DECODER_STREAM_LAST_EN
                            r_out_last <= (w_idx_next == r_len);
`endif
                        end
                    end
                end
                ST_DONE: begin
                    r_idx   <= '0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = w_idle;
    assign busy      = !w_idle;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign done      = r_done;
`ifdef DECODER_STREAM_LAST_EN
    assign out_last  = r_out_last;
`endif

endmodule
